div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one pipelined signed divider among NUM_REQ requester channels (e.g. I/Q or L/R demod paths) in the FM radio datapath. It pulls operand pairs from per-requester dividend/divisor FIFOs, picks a requester each cycle and presents that pair to the divider through a FIFO-style read interface. It tags every issued operation and steers each returning quotient to the originating requester's output FIFO. The divider's internal pipeline cannot stall, so the block's credit limit guarantees that no returning result is ever dropped.

## Interface
- NUM_REQ, 2: requester channels, 2..8
- WIDTH, 32: operand/quotient width
- MAX_INFLIGHT, 64: power of 2; depth of the tag and result FIFOs; must be ≥ divider latency + 2
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_a_empty  in  NUM_REQ  per-requester dividend FIFO empty
- req_a_dout  in  NUM_REQ*WIDTH  dividends, requester r at [r*WIDTH +: WIDTH], first-word-fall-through
- req_a_rd_en  out  NUM_REQ  dividend pop
- req_b_empty / req_b_dout / req_b_rd_en: divisor FIFOs, same shapes
- div_empty  out  1  issue slot empty (divider input-FIFO view)
- div_a_dout, div_b_dout  out  WIDTH  slot dividend / divisor
- div_rd_en  in  1  divider consumes slot
- div_out_full  out  1  result FIFO full
- div_out_wr_en  in  1  divider result valid
- div_out_din  in  WIDTH  quotient
- rsp_full  in  NUM_REQ  per-requester output FIFO full
- rsp_wr_en  out  NUM_REQ  one-hot output write
- rsp_din  out  WIDTH  quotient, broadcast to all requesters
- err_orphan  out  1  sticky: result arrived with no outstanding tag

## Operation
- Issue slot: registers slot_valid, slot_a, slot_b, slot_tag.
- Eligible requester r: !req_a_empty[r] && !req_b_empty[r].
- Grant allowed when (!slot_valid || div_rd_en) && outstanding < MAX_INFLIGHT. outstanding = tag FIFO count + slot_valid, taken from registered values, so the check is conservative.
- On grant to r: req_a_rd_en[r] = req_b_rd_en[r] = 1 (combinational, single bit set). Slot loads r's data and r's tag on the same edge.
- Round-robin: the search starts at last_grant+1 modulo NUM_REQ. last_grant updates only on a grant.
- div_rd_en && slot_valid pushes slot_tag into the tag FIFO. The slot clears unless it reloads in the same cycle. div_rd_en while the slot is empty is ignored.
- div_out_wr_en pushes div_out_din into the result FIFO.
- If div_out_wr_en arrives when the result FIFO count already equals the tag FIFO count: do not push, and set err_orphan. err_orphan is cleared only by reset.
- Drain: when the result FIFO is non-empty and !rsp_full[tag_head], then rsp_wr_en[tag_head] = 1 and rsp_din = result head. Both FIFOs pop.
- Ordering: results return in issue order. A blocked head stalls all channels (head-of-line blocking is accepted). The credit limit bounds result FIFO occupancy ≤ tag occupancy ≤ MAX_INFLIGHT, so no overflow occurs.
- Widths: tag width = $clog2(NUM_REQ), minimum 1. FIFO counters are $clog2(MAX_INFLIGHT)+1 bits.

## Timing
- Reset values: all rd_en and wr_en outputs 0; div_empty 1; div_a_dout, div_b_dout, rsp_din 0; div_out_full 0; err_orphan 0. last_grant = NUM_REQ-1, so requester 0 wins first. Both FIFOs are emptied.
- Reset mid-operation: in-flight tags are discarded. Results the divider delivers afterwards set err_orphan; the system resets the divider together with this block.
- Latency: eligible at cycle n → rd_en in cycle n → div_empty low at n+1.
- Divider result at edge m → rsp_wr_en combinational in cycle m+1, provided the FIFO was empty and rsp_full is low.
- Throughput: one issue per cycle is sustained while div_rd_en stays high and credits remain.
- Simultaneous events: tag push and pop in the same cycle leave the count unchanged. Result push and pop in the same cycle are legal at any occupancy, including full.

## Configuration
- DIV_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; last_grant is not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Single requester: r0 pushes (100, 7), (-100, 7), (100, -1). Divider model with latency 35 → rsp_wr_en[0] three times with 14, -14, -100, in order. rsp_wr_en[1] never asserts.
- Two requesters both always eligible, 8 ops each → grants alternate 0,1,0,1…. Each channel receives exactly its own 8 quotients. Under DIV_ARB_FIXED_PRIO_EN, all r0 ops issue before any r1 op.
- Credit limit: MAX_INFLIGHT=64, div_rd_en held high, rsp_full all high → exactly 64 ops accepted (tags + slot), then all rd_en stay 0. Release rsp_full → all 64 results drain, then issue resumes.
- HOL blocking: results tagged 1 then 0, with rsp_full[1]=1 for 20 cycles → no rsp_wr_en for 20 cycles, then r1 is written followed by r0.
- Orphan: after reset, pulse div_out_wr_en with no issue → err_orphan=1 next cycle, rsp_wr_en stays 0, and err_orphan holds until reset.
- Reset mid-stream with 10 in flight → next cycle all outputs at reset values and div_empty=1.

Source files
------------

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: link between div_arbiter and the shared pipelined divider.
// The arbiter looks like a FIFO to the divider on both sides: the issue slot
// is read like a first-word-fall-through FIFO, and results are written into
// the arbiter's result FIFO.
//
// Signals
//   div_empty      issue slot empty (arbiter -> divider)
//   div_a_dout     slot dividend    (arbiter -> divider)
//   div_b_dout     slot divisor     (arbiter -> divider)
//   div_rd_en      divider consumes the slot (divider -> arbiter)
//   div_out_full   result FIFO full (arbiter -> divider)
//   div_out_wr_en  divider result valid (divider -> arbiter)
//   div_out_din    quotient         (divider -> arbiter)
//
// Modports: master = divider side, slave = arbiter side.
interface div_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             div_empty;
  logic [WIDTH-1:0] div_a_dout;
  logic [WIDTH-1:0] div_b_dout;
  logic             div_rd_en;
  logic             div_out_full;
  logic             div_out_wr_en;
  logic [WIDTH-1:0] div_out_din;

  modport master (
    input  div_empty, div_a_dout, div_b_dout, div_out_full,
    output div_rd_en, div_out_wr_en, div_out_din
  );

  modport slave (
    output div_empty, div_a_dout, div_b_dout, div_out_full,
    input  div_rd_en, div_out_wr_en, div_out_din
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: shares one non-stalling pipelined signed divider among NUM_REQ
// requesters. Operand pairs are pulled from per-requester FIFOs into a single
// issue slot, each issued operation is tagged with its requester, and the
// returning quotients are steered back in issue order.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   req_a_empty/dout     per-requester dividend FIFOs (FWFT), requester r at
//                        [r*WIDTH +: WIDTH]
//   req_a_rd_en          dividend pop, one-hot
//   req_b_*              divisor FIFOs, same shapes
//   div                  divider link (div_arbiter_if.slave)
//   rsp_full             per-requester output FIFO full
//   rsp_wr_en            one-hot output write
//   rsp_din              quotient, broadcast to all requesters
//   err_orphan           sticky: a result arrived with no outstanding tag
//
// Optional feature macro: DIV_ARB_FIXED_PRIO_EN
//   defined   : fixed priority, lowest requester index wins
//   undefined : round-robin starting after the last granted requester
module div_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 32,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_a_empty,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_dout,
  output logic [NUM_REQ-1:0]       req_a_rd_en,
  input  logic [NUM_REQ-1:0]       req_b_empty,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_dout,
  output logic [NUM_REQ-1:0]       req_b_rd_en,
  div_arbiter_if.slave             div,
  input  logic [NUM_REQ-1:0]       rsp_full,
  output logic [NUM_REQ-1:0]       rsp_wr_en,
  output logic [WIDTH-1:0]         rsp_din,
  output logic                     err_orphan
);

  localparam int TAGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW   = $clog2(MAX_INFLIGHT);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_dout[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b_dout[g*WIDTH +: WIDTH];
  end

  // issue slot
  logic             slot_valid;
  logic [WIDTH-1:0] slot_a;
  logic [WIDTH-1:0] slot_b;
  logic [TAGW-1:0]  slot_tag;

  // tag FIFO: requester of every operation the divider has accepted
  logic [TAGW-1:0]  tag_mem [MAX_INFLIGHT];
  logic [PW-1:0]    tag_wp, tag_rp;
  logic [CW-1:0]    tag_cnt;

  // result FIFO: quotients waiting for their requester
  logic [WIDTH-1:0] res_mem [MAX_INFLIGHT];
  logic [PW-1:0]    res_wp, res_rp;
  logic [CW-1:0]    res_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic [CW:0]        outstanding;
  logic               grant_ok;
  logic               grant;
  logic [TAGW-1:0]    grant_idx;
  logic [TAGW-1:0]    cand_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [TAGW-1:0]    tag_head;
  logic [WIDTH-1:0]   res_head;
  logic               drain;
  logic               tag_push;
  logic               orphan;
  logic               res_push;

`ifndef DIV_ARB_FIXED_PRIO_EN
  logic [TAGW-1:0]    last_grant;
`endif

  assign eligible = ~req_a_empty & ~req_b_empty;

  // Credit count uses registered values only; a slot being consumed this
  // cycle still counts, so the limit is conservative by at most one op.
  assign outstanding = {1'b0, tag_cnt} + {{CW{1'b0}}, slot_valid};
  assign grant_ok    = !reset && (!slot_valid || div.div_rd_en) &&
                       (outstanding < {1'b0, MAX_CNT});

  always_comb begin
    int cand;
    grant     = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef DIV_ARB_FIXED_PRIO_EN
      cand = i;
`else
      cand = int'(last_grant) + 1 + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
`endif
      cand_idx = TAGW'(cand);
      if (grant_ok && !grant && eligible[cand_idx]) begin
        grant     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign req_a_rd_en = grant_oh;
  assign req_b_rd_en = grant_oh;

  assign tag_head = tag_mem[tag_rp];
  assign res_head = res_mem[res_rp];

  // A non-empty result FIFO always has a matching tag at the tag head.
  assign drain = !reset && (res_cnt != '0) && !rsp_full[tag_head];

  always_comb begin
    rsp_wr_en = '0;
    rsp_din   = '0;
    if (drain) begin
      rsp_wr_en[tag_head] = 1'b1;
      rsp_din             = res_head;
    end
  end

  assign tag_push = slot_valid && div.div_rd_en;
  assign orphan   = div.div_out_wr_en && (res_cnt == tag_cnt);
  assign res_push = div.div_out_wr_en && !orphan;

  assign div.div_empty    = !slot_valid;
  assign div.div_a_dout   = slot_a;
  assign div.div_b_dout   = slot_b;
  assign div.div_out_full = (res_cnt == MAX_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_a     <= '0;
      slot_b     <= '0;
      slot_tag   <= '0;
      tag_wp     <= '0;
      tag_rp     <= '0;
      tag_cnt    <= '0;
      res_wp     <= '0;
      res_rp     <= '0;
      res_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant) begin
        slot_valid <= 1'b1;
        slot_a     <= a_arr[grant_idx];
        slot_b     <= b_arr[grant_idx];
        slot_tag   <= grant_idx;
      end else if (div.div_rd_en) begin
        slot_valid <= 1'b0;
      end

      if (tag_push) begin
        tag_wp <= tag_wp + PW'(1);
      end
      if (res_push) begin
        res_wp <= res_wp + PW'(1);
      end
      if (drain) begin
        tag_rp <= tag_rp + PW'(1);
        res_rp <= res_rp + PW'(1);
      end

      case ({tag_push, drain})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase

      case ({res_push, drain})
        2'b10:   res_cnt <= res_cnt + CW'(1);
        2'b01:   res_cnt <= res_cnt - CW'(1);
        default: res_cnt <= res_cnt;
      endcase

      if (orphan) begin
        err_orphan <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tag_push) begin
      tag_mem[tag_wp] <= slot_tag;
    end
    if (res_push) begin
      res_mem[res_wp] <= div.div_out_din;
    end
  end

`ifndef DIV_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= TAGW'(NUM_REQ - 1);
    end else if (grant) begin
      last_grant <= grant_idx;
    end
  end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: requester FIFOs and a fixed-latency divider are
// modelled here; a transaction-level model predicts grants, slot contents,
// credit behaviour and the in-order return of quotients.
module tb_div_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int WIDTH        = 32;
  localparam int MAX_INFLIGHT = 64;
  localparam int LAT          = 35;
`ifdef DIV_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req_a_empty, req_b_empty;
  logic [NUM_REQ*WIDTH-1:0] req_a_dout, req_b_dout;
  logic [NUM_REQ-1:0]       req_a_rd_en, req_b_rd_en;
  logic [NUM_REQ-1:0]       rsp_full;
  logic [NUM_REQ-1:0]       rsp_wr_en;
  logic [WIDTH-1:0]         rsp_din;
  logic                     err_orphan;

  div_arbiter_if #(.WIDTH(WIDTH)) dif ();

  div_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_a_empty(req_a_empty), .req_a_dout(req_a_dout), .req_a_rd_en(req_a_rd_en),
    .req_b_empty(req_b_empty), .req_b_dout(req_b_dout), .req_b_rd_en(req_b_rd_en),
    .div(dif.slave),
    .rsp_full(rsp_full), .rsp_wr_en(rsp_wr_en), .rsp_din(rsp_din),
    .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {logic [31:0] a; logic [31:0] b;} op_t;
  typedef struct {int tag; logic [31:0] q;} iss_t;

  op_t         rq [NUM_REQ][$];
  iss_t        m_iss[$];
  int          m_res_cnt = 0;
  bit          m_err = 0;
  bit          m_slot_v = 0;
  logic [31:0] m_slot_a = 0, m_slot_b = 0;
  int          m_slot_tag = 0;
  int          m_last = NUM_REQ - 1;

  bit          pv [LAT];
  logic [31:0] pq [LAT];
  bit          inject = 0;
  bit          rd_mode = 0;

  int          e_grant = -1;
  bit          e_drain = 0;
  bit          s_rd = 0, s_take = 0, s_wr = 0, s_reset = 1;
  logic [31:0] s_a = 0, s_b = 0;

  int          checks = 0;
  int          errors = 0;
  int          obs_grants[$];
  logic [31:0] obs_q [NUM_REQ][$];
  int          obs_order[$];
  int          wr_count = 0;

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    return sa / sb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit idle();
    bit r;
    r = !m_slot_v && (m_iss.size() == 0);
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) r = 0;
    for (int i = 0; i < LAT; i++) if (pv[i]) r = 0;
    return r;
  endfunction

  task automatic drive_inputs();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_a_empty[r] = (rq[r].size() == 0);
      req_b_empty[r] = (rq[r].size() == 0);
      req_a_dout[r*WIDTH +: WIDTH] = (rq[r].size() != 0) ? rq[r][0].a : 32'h0;
      req_b_dout[r*WIDTH +: WIDTH] = (rq[r].size() != 0) ? rq[r][0].b : 32'h0;
    end
    dif.div_out_wr_en = pv[LAT-1] | inject;
    dif.div_out_din   = pv[LAT-1] ? pq[LAT-1] : 32'h0;
    dif.div_rd_en     = rd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // compare process: predicts this cycle's outputs from the model
  always @(negedge clock) begin
    logic [1:0] exp_oh, exp_wr;
    bit         allowed;
    int         c;
    s_reset = reset;
    s_rd    = dif.div_rd_en;
    s_take  = dif.div_rd_en && !dif.div_empty;
    s_a     = dif.div_a_dout;
    s_b     = dif.div_b_dout;
    s_wr    = dif.div_out_wr_en;
    e_grant = -1;
    e_drain = 0;
    if (!reset) begin
      allowed = (!m_slot_v || dif.div_rd_en) &&
                ((m_iss.size() + int'(m_slot_v)) < MAX_INFLIGHT);
      if (allowed) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          c = FIXED ? i : (m_last + 1 + i) % NUM_REQ;
          if (e_grant < 0 && rq[c].size() > 0) e_grant = c;
        end
      end
      e_drain = (m_res_cnt > 0) && !rsp_full[m_iss[0].tag];
      exp_oh = (e_grant >= 0) ? 2'(1 << e_grant) : 2'b00;
      exp_wr = e_drain ? 2'(1 << m_iss[0].tag) : 2'b00;
      chk("req_a_rd_en", 64'(req_a_rd_en), 64'(exp_oh));
      chk("req_b_rd_en", 64'(req_b_rd_en), 64'(exp_oh));
      chk("div_empty", 64'(dif.div_empty), 64'(!m_slot_v));
      if (m_slot_v) begin
        chk("div_a_dout", 64'(dif.div_a_dout), 64'(m_slot_a));
        chk("div_b_dout", 64'(dif.div_b_dout), 64'(m_slot_b));
      end
      chk("rsp_wr_en", 64'(rsp_wr_en), 64'(exp_wr));
      if (e_drain) chk("rsp_din", 64'(rsp_din), 64'(m_iss[0].q));
      chk("div_out_full", 64'(dif.div_out_full), 64'(m_res_cnt == MAX_INFLIGHT));
      chk("err_orphan", 64'(err_orphan), 64'(m_err));
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_a_rd_en[r]) obs_grants.push_back(r);
        if (rsp_wr_en[r]) begin
          obs_q[r].push_back(rsp_din);
          obs_order.push_back(r);
          wr_count++;
        end
      end
    end
  end

  task automatic model_reset();
    m_iss.delete();
    m_res_cnt  = 0;
    m_err      = 0;
    m_slot_v   = 0;
    m_slot_a   = 0;
    m_slot_b   = 0;
    m_slot_tag = 0;
    m_last     = NUM_REQ - 1;
  endtask

  task automatic tick();
    bit   orph;
    iss_t e;
    @(posedge clock);
    #1;
    if (s_reset) begin
      model_reset();
      for (int i = 0; i < LAT; i++) pv[i] = 0;
    end else begin
      orph = s_wr && (m_res_cnt == m_iss.size());
      if (s_rd && m_slot_v) begin
        e.tag = m_slot_tag;
        e.q   = sdiv(m_slot_a, m_slot_b);
        m_iss.push_back(e);
      end
      if (e_grant >= 0) begin
        m_slot_v   = 1;
        m_slot_a   = rq[e_grant][0].a;
        m_slot_b   = rq[e_grant][0].b;
        m_slot_tag = e_grant;
        m_last     = e_grant;
        void'(rq[e_grant].pop_front());
      end else if (s_rd) begin
        m_slot_v = 0;
      end
      if (s_wr) begin
        if (orph) m_err = 1;
        else m_res_cnt++;
      end
      if (e_drain) begin
        void'(m_iss.pop_front());
        m_res_cnt--;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pq[i] = pq[i-1];
      end
      pv[0] = s_take;
      pq[0] = s_take ? sdiv(s_a, s_b) : 32'h0;
    end
    drive_inputs();
  endtask

  task automatic clear_obs();
    obs_grants.delete();
    obs_order.delete();
    for (int r = 0; r < NUM_REQ; r++) obs_q[r].delete();
    wr_count = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    inject = 0;
    for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
    for (int i = 0; i < LAT; i++) pv[i] = 0;
    drive_inputs();
    tick();
    reset = 1'b0;
    drive_inputs();
    clear_obs();
  endtask

  task automatic push_op(input int r, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    rq[r].push_back(o);
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, 64'(idle()), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_div_empty"}, 64'(dif.div_empty), 64'd1);
    chk({name, "_div_a"}, 64'(dif.div_a_dout), 64'd0);
    chk({name, "_div_b"}, 64'(dif.div_b_dout), 64'd0);
    chk({name, "_rsp_din"}, 64'(rsp_din), 64'd0);
    chk({name, "_rd_en"}, 64'({req_a_rd_en, req_b_rd_en}), 64'd0);
    chk({name, "_rsp_wr"}, 64'(rsp_wr_en), 64'd0);
    chk({name, "_full"}, 64'(dif.div_out_full), 64'd0);
    chk({name, "_err"}, 64'(err_orphan), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int w0;
    int exp_g;
    rsp_full = '0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 0;
      pq[i] = 0;
    end
    drive_inputs();
    #1;
    tick();
    apply_reset();
    check_reset_outputs("reset");

    // single requester, signed quotients
    push_op(0, 32'd100, 32'd7);
    push_op(0, -32'sd100, 32'd7);
    push_op(0, 32'd100, -32'sd1);
    drive_inputs();
    run_until_idle(200, "single");
    chk("single_count0", 64'(obs_q[0].size()), 64'd3);
    chk("single_q0", 64'(obs_q[0][0]), 64'h0000_000E);
    chk("single_q1", 64'(obs_q[0][1]), 64'hFFFF_FFF2);
    chk("single_q2", 64'(obs_q[0][2]), 64'hFFFF_FF9C);
    chk("single_count1", 64'(obs_q[1].size()), 64'd0);

    // two requesters always eligible, irregular divider reads
    apply_reset();
    rd_mode = 1;
    for (int i = 0; i < 8; i++) begin
      push_op(0, 32'(1000 + 37 * i), 32'(i + 1));
      push_op(1, 32'(-(500 + 11 * i)), (i % 2) ? 32'(-(i + 2)) : 32'(i + 3));
    end
    drive_inputs();
    run_until_idle(600, "pair");
    rd_mode = 0;
    drive_inputs();
    chk("pair_grants", 64'(obs_grants.size()), 64'd16);
    for (int k = 0; k < 16; k++) begin
      exp_g = FIXED ? ((k < 8) ? 0 : 1) : (k % 2);
      chk("pair_grant_order", 64'(obs_grants[k]), 64'(exp_g));
    end
    chk("pair_count0", 64'(obs_q[0].size()), 64'd8);
    chk("pair_count1", 64'(obs_q[1].size()), 64'd8);

    // credit limit with outputs blocked
    apply_reset();
    rsp_full = 2'b11;
    for (int i = 0; i < 80; i++) push_op(0, 32'(13 * i + 5), 32'((i % 5) + 1));
    drive_inputs();
    for (int i = 0; i < 150; i++) tick();
    chk("credit_grants", 64'(obs_grants.size()), 64'd64);
    chk("credit_full", 64'(dif.div_out_full), 64'd1);
    chk("credit_rd_idle", 64'(req_a_rd_en), 64'd0);
    chk("credit_no_wr", 64'(wr_count), 64'd0);
    rsp_full = 2'b00;
    drive_inputs();
    run_until_idle(600, "credit");
    chk("credit_total_grants", 64'(obs_grants.size()), 64'd80);
    chk("credit_total_rsp", 64'(obs_q[0].size()), 64'd80);

    // head-of-line blocking: tag 1 then tag 0, requester 1 blocked
    apply_reset();
    rsp_full = 2'b10;
    push_op(1, 32'd50, 32'd5);
    drive_inputs();
    tick();
    push_op(0, -32'sd9, 32'd2);
    drive_inputs();
    n = 0;
    while (m_res_cnt < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("hol_results_in", 64'(m_res_cnt), 64'd2);
    w0 = wr_count;
    for (int i = 0; i < 20; i++) tick();
    chk("hol_blocked", 64'(wr_count - w0), 64'd0);
    rsp_full = 2'b00;
    drive_inputs();
    run_until_idle(50, "hol");
    chk("hol_writes", 64'(obs_order.size()), 64'd2);
    chk("hol_first", 64'(obs_order[0]), 64'd1);
    chk("hol_second", 64'(obs_order[1]), 64'd0);
    chk("hol_q1", 64'(obs_q[1][0]), 64'h0000_000A);
    chk("hol_q0", 64'(obs_q[0][0]), 64'hFFFF_FFFC);

    // orphan result
    apply_reset();
    inject = 1;
    drive_inputs();
    tick();
    inject = 0;
    drive_inputs();
    chk("orphan_set", 64'(err_orphan), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("orphan_hold", 64'(err_orphan), 64'd1);
    chk("orphan_no_wr", 64'(wr_count), 64'd0);
    apply_reset();
    chk("orphan_clear", 64'(err_orphan), 64'd0);

    // reset with operations in flight
    apply_reset();
    rsp_full = 2'b11;
    for (int i = 0; i < 15; i++) begin
      push_op(0, 32'(700 + i), 32'd3);
      push_op(1, 32'(-(900 + i)), 32'd4);
    end
    drive_inputs();
    n = 0;
    while (m_iss.size() < 10 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_inflight", 64'(m_iss.size() >= 10), 64'd1);
    rsp_full = 2'b00;
    apply_reset();
    check_reset_outputs("mid");
    for (int i = 0; i < 40; i++) tick();
    chk("mid_quiet", 64'(wr_count + obs_grants.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
